// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Request/result bundle between the EX stage and the
//                multi-cycle divider.
//  Revision    : 1.0
// ============================================================================
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    // EX stage side: issues the request, consumes the result
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // Divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : 32-bit restoring radix-2 divider for DIV/DIVU, one quotient
//                bit per clock. result_o = {remainder, quotient}.
//  Revision    : 1.0
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,      // asynchronous, active-low
    div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [5:0]           cnt_q,       cnt_d;
    logic [2*WIDTH:0]     work_q,      work_d;      // {partial_rem[32:0], dividend/quotient[31:0]}
    logic [WIDTH-1:0]     divisor_q,   divisor_d;
    logic                 neg_quot_q,  neg_quot_d;
    logic                 neg_rem_q,   neg_rem_d;
    logic [2*WIDTH-1:0]   result_q,    result_d;
    logic                 ready_q,     ready_d;

    logic [WIDTH-1:0]     abs_dividend;
    logic [WIDTH-1:0]     abs_divisor;
    logic [2*WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]     trial;
    logic [2*WIDTH:0]     iter_next;
    logic [WIDTH-1:0]     quot_raw;
    logic [WIDTH-1:0]     rem_raw;
    logic [WIDTH-1:0]     quot_fixed;
    logic [WIDTH-1:0]     rem_fixed;

    // Operand magnitudes and one restoring iteration on the working register
    always_comb begin
        abs_dividend = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
        abs_divisor  = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

        // Shift by one, then try to subtract the divisor from the upper part.
        // The extra top bit of trial acts as the borrow / sign.
        shifted = {work_q, 1'b0};
        trial   = shifted[2*WIDTH+1:WIDTH] - {2'b00, divisor_q};
        if (trial[WIDTH+1]) begin
            iter_next = shifted[2*WIDTH:0];
        end else begin
            iter_next = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        end

        quot_raw   = iter_next[WIDTH-1:0];
        rem_raw    = iter_next[2*WIDTH-1:WIDTH];
        quot_fixed = neg_quot_q ? (~quot_raw + 1'b1) : quot_raw;
        rem_fixed  = neg_rem_q  ? (~rem_raw  + 1'b1) : rem_raw;
    end

    // Next-state and registered-output computation for the divider FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = 6'd0;
                        work_d     = {{(WIDTH+1){1'b0}}, abs_dividend};
                        divisor_d  = abs_divisor;
                        neg_quot_d = bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        neg_rem_d  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                    end
                end
            end

            S_BYZERO: begin
                // Divide by zero reports quotient 0 and remainder 0
                work_d   = '0;
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = S_END;
            end

            S_ON: begin
                if (bus.annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    work_d = iter_next;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        // Final iteration: publish the sign-corrected result
                        state_d  = S_END;
                        cnt_d    = 6'd0;
                        ready_d  = 1'b1;
                        result_d = {rem_fixed, quot_fixed};
                    end
                end
            end

            S_END: begin
                ready_d = 1'b1;
                if (bus.annul_i || !bus.start_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = S_FREE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // State and output registers; reset acts immediately, independent of clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FREE;
            cnt_q      <= 6'd0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule
`default_nettype wire
